// File: rtl/divider_iceqman.sv
// rtl/divider_iceqman.sv - sequential 16/8 restoring divider, one quotient bit per clock
module divider_iceqman (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [15:0] quotient,
    output logic [7:0]  remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [15:0] q;
    logic [8:0]  r;
    logic [7:0]  d;
    logic [3:0]  count;

    logic [8:0]  shifted;
    logic        fits;
    logic [8:0]  r_step;
    logic [15:0] q_step;

    // One restoring step: shift next dividend bit into r, subtract d when it fits.
    // The compare keeps r[8] in view; it is always zero while iterating.
    always_comb begin
        shifted = {r[7:0], q[15]};
        fits    = ({r, q[15]} >= {2'b00, d});
        r_step  = shifted;
        if (fits) begin
            r_step = shifted - {1'b0, d};
        end
        q_step  = {q[14:0], fits};
    end

    // Next-state logic and status outputs decoded from the state register.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (count == 4'd15) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset abandons any calculation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working registers and result outputs; the last step loads results directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            q           <= 16'd0;
            r           <= 9'd0;
            d           <= 8'd0;
            count       <= 4'd0;
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != 8'd0) begin
                            q           <= dividend;
                            r           <= 9'd0;
                            d           <= divisor;
                            count       <= 4'd0;
                            div_by_zero <= 1'b0;
                        end else begin
                            quotient    <= 16'hFFFF;
                            remainder   <= dividend[7:0];
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q     <= q_step;
                    r     <= r_step;
                    count <= count + 4'd1;
                    if (count == 4'd15) begin
                        quotient  <= q_step;
                        remainder <= r_step[7:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_iceqman.sv
// tb/tb_divider_iceqman.sv - self-checking bench for divider_iceqman
module tb_divider_iceqman;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [15:0] quotient;
    logic [7:0]  remainder;

    int checks = 0;
    int errors = 0;

    divider_iceqman dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer division, with the fixed divide-by-zero result.
    task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                           output logic [15:0] eq, output logic [7:0] er, output logic ez);
        int ai;
        int bi;
        ai = int'(a);
        bi = int'(b);
        if (bi == 0) begin
            eq = 16'hFFFF;
            er = a[7:0];
            ez = 1'b1;
        end else begin
            eq = 16'(ai / bi);
            er = 8'(ai % bi);
            ez = 1'b0;
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Issue one start pulse and check timing, results and single done pulse.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic ez,
                          input string tag);
        int n_busy;
        int done_at;
        int overlap;
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n_busy   = 0;
        done_at  = -1;
        overlap  = 0;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            if (busy && done) overlap++;
            if (done) begin
                done_at = k;
            end else begin
                if (busy) n_busy++;
                dividend = 16'($urandom);
                divisor  = 8'($urandom);
                tick();
            end
        end
        chk({tag, ".done_at"}, 32'(done_at), (b == 8'd0) ? 32'd0 : 32'd16);
        chk({tag, ".busy_cycles"}, 32'(n_busy), (b == 8'd0) ? 32'd0 : 32'd16);
        chk({tag, ".overlap"}, 32'(overlap), 32'd0);
        chk({tag, ".quotient"}, 32'(quotient), 32'(eq));
        chk({tag, ".remainder"}, 32'(remainder), 32'(er));
        chk({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(ez));
        if (b != 8'd0) begin
            chk({tag, ".invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
        end
        tick();
        chk({tag, ".after_done"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ez;
        logic [15:0] ra;
        logic [7:0]  rb;
        int pulses;
        int done_at;
        int done_times[$];
        int idle_seen;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,    1'b0};
        vecs[1] = '{16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0};
        vecs[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,    1'b0};
        vecs[3] = '{16'd5,     8'd9,   16'd0,     8'd5,    1'b0};
        vecs[4] = '{16'd0,     8'd3,   16'd0,     8'd0,    1'b0};
        vecs[5] = '{16'h04D2,  8'd0,   16'hFFFF,  8'hD2,   1'b1};
        vecs[6] = '{16'd100,   8'd10,  16'd10,    8'd0,    1'b0};
        vecs[7] = '{16'd255,   8'd255, 16'd1,     8'd0,    1'b0};

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 8'd0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("reset_idle", {5'd0, busy, done, div_by_zero, quotient, remainder}, 32'd0);
        end

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].eq, vecs[i].er, vecs[i].ez,
                   $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            if (i % 5 == 1) rb = 8'($urandom_range(1, 4));
            ref_div(ra, rb, eq, er, ez);
            run_op(ra, rb, eq, er, ez, $sformatf("rand%0d", i));
        end

        // Start pulses with new operands during CALC are ignored.
        @(negedge clock);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        pulses  = 0;
        done_at = -1;
        for (int k = 0; k < 25; k++) begin
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = k;
            end
            if (k == 3 || k == 9) begin
                dividend = 16'd50000;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        chk("busy_start.pulses", 32'(pulses), 32'd1);
        chk("busy_start.done_at", 32'(done_at), 32'd16);
        chk("busy_start.quotient", 32'(quotient), 32'd142);
        chk("busy_start.remainder", 32'(remainder), 32'd6);

        // Held start gives back-to-back operations every 18 cycles.
        @(negedge clock);
        dividend = 16'd300;
        divisor  = 8'd7;
        start    = 1'b1;
        done_times.delete();
        for (int k = 0; k < 60; k++) begin
            tick();
            if (done) done_times.push_back(k);
        end
        @(negedge clock);
        start = 1'b0;
        chk("held.count", (done_times.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
        if (done_times.size() >= 3) begin
            chk("held.gap1", 32'(done_times[1] - done_times[0]), 32'd18);
            chk("held.gap2", 32'(done_times[2] - done_times[1]), 32'd18);
        end
        chk("held.quotient", 32'(quotient), 32'd42);
        chk("held.remainder", 32'(remainder), 32'd6);
        idle_seen = 0;
        for (int k = 0; k < 40 && idle_seen == 0; k++) begin
            tick();
            if (!busy && !done) idle_seen = 1;
        end
        chk("held.drain", 32'(idle_seen), 32'd1);

        // Reset in the middle of CALC abandons the operation.
        @(negedge clock);
        dividend = 16'd1000;
        divisor  = 8'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("midreset.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset.outputs", {5'd0, busy, done, div_by_zero, quotient, remainder}, 32'd0);
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done || busy) pulses++;
        end
        chk("midreset.no_done", 32'(pulses), 32'd0);
        run_op(16'd200, 8'd13, 16'd15, 8'd5, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
